// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: stage enables/flushes,
// load-use stalls, branch/jump flushes, EX forwarding and a data-memory wait watchdog.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_to_reg,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_access,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_err
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [15:0]      WAIT_LAST = 16'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             state_reg, state_next;
  logic [15:0]        wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]   stall_cnt_reg;
  logic               mem_err_reg, mem_err_next;
  logic               freeze;
  logic               load_use;

  // Forwarding source select for one EX operand; MEM result is newer than WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == src))
      sel = 2'b10;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == src))
      sel = 2'b01;
    return sel;
  endfunction

  assign load_use = ex_mem_to_reg && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      wait_cnt_reg  <= 16'd0;
      stall_cnt_reg <= '0;
      mem_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_next;
      if (!pc_en && (stall_cnt_reg != CNT_MAX))
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
    end
  end

  // Memory handshake FSM: decides the freeze and the next state together.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    mem_err_next  = mem_err_reg;
    freeze        = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (mem_access && !dmem_ready) begin
          freeze        = 1'b1;
          state_next    = ST_WAIT;
          wait_cnt_next = 16'd0;
        end
      end
      ST_WAIT: begin
        if (dmem_ready) begin
          state_next = ST_RUN;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_reg == WAIT_LAST) begin
            state_next   = ST_ERR;
            mem_err_next = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt_reg + 16'd1;
          end
        end
      end
      ST_ERR: begin
        freeze = 1'b1;
      end
      default: begin
        freeze     = 1'b1;
        state_next = ST_RUN;
      end
    endcase
  end

  // Stage control; everything is held inactive while reset is asserted.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst_n && !freeze) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, inject one bubble into EX; a pending jump waits.
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (id_jump) begin
        if_id_flush = 1'b1;
      end
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst_n) begin
      fwd_a = fwd_sel(ex_rs);
      fwd_b = fwd_sel(ex_rt);
    end
  end

  assign dmem_req  = rst_n && mem_access && (state_reg != ST_ERR);
  assign stall_cnt = stall_cnt_reg;
  assign mem_err   = mem_err_reg;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core; sits beside the instruction decoder and drives stage-register enables and flushes. Detects load-use hazards, flushes on taken branches and jumps, and generates EX-stage forwarding selects. Freezes the pipeline while the data memory is not ready, via a req/ready handshake with a timeout watchdog. Counts stall cycles for performance debug.

Parameters:
MEM_TIMEOUT, 255, max consecutive WAIT cycles before entering ERR (1..65535)
CNT_W, 16, width of stall_cnt

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
id_uses_rt  input  1  ID instruction reads rt (R-type, beq, bne, sw)
id_jump  input  1  j decoded in ID
ex_rs  input  5  rs of instruction in EX
ex_rt  input  5  rt of instruction in EX
ex_rd  input  5  destination register of EX instruction (after reg_dst mux)
ex_mem_to_reg  input  1  EX instruction is lw
ex_branch_taken  input  1  beq/bne resolved taken in EX
mem_rd  input  5  destination register in MEM
mem_reg_write  input  1  MEM instruction writes a register
mem_access  input  1  MEM instruction is lw or sw
wb_rd  input  5  destination register in WB
wb_reg_write  input  1  WB instruction writes a register
dmem_ready  input  1  data memory completes access this cycle
dmem_req  output  1  data memory request
pc_en  output  1  PC update enable
if_id_en  output  1  IF/ID register enable
id_ex_en  output  1  ID/EX register enable
ex_mem_en  output  1  EX/MEM register enable
mem_wb_en  output  1  MEM/WB register enable
if_id_flush  output  1  load NOP into IF/ID
id_ex_flush  output  1  load NOP into ID/EX
fwd_a  output  2  ALU operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b  output  2  ALU operand B select, same encoding
stall_cnt  output  CNT_W  saturating count of cycles with pc_en=0
mem_err  output  1  sticky memory-timeout flag

Behaviour:
- State register: RUN, WAIT, ERR. wait_cnt: 16 bits.
- Reset (async, rst_n low): state=RUN, wait_cnt=0, stall_cnt=0, mem_err=0. While rst_n is low, all enables, flushes and dmem_req are 0, and fwd_a=fwd_b=00.
- Every state: dmem_req = mem_access, except in ERR, where it is 0.
- freeze: RUN with mem_access & !dmem_ready, or WAIT with !dmem_ready, or any cycle in ERR. During freeze, all five enables are 0 and both flushes are 0. Freeze has highest priority and masks all other causes.
- Transitions:
  - RUN to WAIT on mem_access & !dmem_ready.
  - WAIT to RUN on dmem_ready; enables are released in that same cycle.
  - WAIT to ERR when dmem_ready is still low and wait_cnt==MEM_TIMEOUT-1. mem_err is set on entry to ERR.
  - ERR holds until reset.
- wait_cnt: cleared on entering WAIT, increments each WAIT cycle.
- When not frozen, priority is as follows:
  1. ex_branch_taken: if_id_flush=1, id_ex_flush=1, all enables 1. The load-use check is ignored because the ID instruction is killed.
  2. Load-use: ex_mem_to_reg & ex_rd!=0 & (ex_rd==id_rs | id_uses_rt & ex_rd==id_rt). Result: pc_en=0, if_id_en=0, id_ex_flush=1, other enables 1. Exactly one bubble per hazard. id_jump is ignored this cycle and is re-evaluated next cycle.
  3. id_jump: if_id_flush=1, all enables 1.
  4. Otherwise: all enables 1, no flush.
- Forwarding (combinational, independent of state):
  - fwd_a=10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs.
  - Else fwd_a=01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs.
  - Else fwd_a=00.
  - fwd_b uses the same rule on ex_rt. MEM has priority over WB.
- stall_cnt: increments on each rising edge where pc_en==0 and rst_n==1. It saturates at all-ones and does not wrap.
- Flushes have no effect while the corresponding enable is 0.

Test Plan:
- Load-use: ex_mem_to_reg=1, ex_rd=5, id_rs=5 -> exactly one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Branch plus load-use in the same cycle: ex_branch_taken=1 with the load-use condition true -> if_id_flush=id_ex_flush=1, pc_en=1, stall_cnt unchanged.
- Forwarding: mem_rd=wb_rd=ex_rs=8, both write -> fwd_a=10. Clear mem_reg_write -> fwd_a=01. ex_rt=0 with a matching rd=0 -> fwd_b=00.
- Memory wait: mem_access=1, dmem_ready low for 3 cycles -> all enables 0 for 3 cycles; released in the cycle dmem_ready=1; stall_cnt=3; state returns to RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready held low -> mem_err=1 after 4 WAIT cycles; enables and dmem_req stay 0 even after dmem_ready=1. Asserting rst_n low mid-ERR clears mem_err, stall_cnt and state asynchronously.
- Saturation: CNT_W=4, hold a load-use condition alternately for 20 stall cycles -> stall_cnt stops at 15.
